tank_shot_ctrl: RTL and testbench
=================================

TANK_SHOT_CTRL -- requirements
Module: tank_shot_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- SHOT_STEP, 4: pixels per frame of shot travel.
- COOLDOWN_FRAMES, 30: frames after shot termination before refire; minimum 1.
- X_MIN, 0: left screen bound.
- X_MAX, 639: right screen bound.
- Y_MIN, 0: top screen bound.
- Y_MAX, 479: bottom screen bound.

REQ-002 Ports (name, direction, width, meaning), one per line:
- frame_clk, in, 1: single clock, one rising edge per video frame.
- Reset, in, 1: asynchronous, active-high reset.
- fire, in, 1: fire key level.
- hit, in, 1: external collision flag for the active shot.
- BarrelX, in, 10: barrel tip X.
- BarrelY, in, 10: barrel tip Y.
- p_direction, in, 2: tank facing. 00 = left, 01 = right, 10 = down, 11 = up.
- ShotX, out, 10: shot centre X.
- ShotY, out, 10: shot centre Y.
- shot_active, out, 1: shot is drawn and collidable.
- ctrl_state, out, 2: 00 = IDLE, 01 = FLIGHT, 10 = COOLDOWN.
- shots_fired, out, 8: launch count.

REQ-003 One clock, frame_clk; Reset is asynchronous and active-high; all outputs are registered.

Function
REQ-004 A fire edge is fire=1 with fire_prev=0, where fire_prev is fire registered on every frame_clk edge regardless of state.
REQ-005 IDLE with a fire edge:
- ShotX<=BarrelX, ShotY<=BarrelY.
- shot_dir<=p_direction.
- shot_active<=1, state<=FLIGHT.
- shots_fired increments.
REQ-006 IDLE without a fire edge: all registers hold.
REQ-007 Fire edges in FLIGHT or COOLDOWN are discarded, never queued.
REQ-008 Holding fire high across a return to IDLE does not launch; the key must be released and pressed again.
REQ-009 shot_dir is latched at launch; p_direction, BarrelX and BarrelY changes during FLIGHT have no effect.
REQ-010 Each FLIGHT edge terminates if hit=1 or the next step would cross a bound:
- shot_dir 00: ShotX < X_MIN+SHOT_STEP.
- shot_dir 01: ShotX > X_MAX-SHOT_STEP.
- shot_dir 10: ShotY > Y_MAX-SHOT_STEP.
- shot_dir 11: ShotY < Y_MIN+SHOT_STEP.
REQ-011 Bound comparisons use 11-bit unsigned arithmetic; ShotX/ShotY never wrap below 0 or exceed the bounds.
REQ-012 Terminate: shot_active<=0, state<=COOLDOWN, cd_cnt<=COOLDOWN_FRAMES-1, ShotX/ShotY hold last value.
REQ-013 FLIGHT without terminate: move SHOT_STEP along shot_dir (00: X-, 01: X+, 10: Y+, 11: Y-); the other axis holds.
REQ-014 hit and out-of-bounds on the same edge cause one termination, identical to REQ-012.
REQ-015 hit is ignored outside FLIGHT.
REQ-016 COOLDOWN: cd_cnt decrements each edge; on the edge where cd_cnt=0, state<=IDLE. COOLDOWN therefore lasts exactly COOLDOWN_FRAMES edges.
REQ-017 shots_fired wraps 255->0 and is not cleared by termination.
REQ-018 Launch latency: shot_active and the barrel position are visible 1 edge after the fire edge is sampled.
REQ-019 Unused state encoding 11 returns to IDLE on the next edge with shot_active=0.

Reset
REQ-020 Reset asserted:
- ShotX=0, ShotY=0.
- shot_active=0, ctrl_state=00.
- shots_fired=0, cd_cnt=0.
- shot_dir=00, fire_prev=0.
REQ-021 Reset applies immediately, independent of frame_clk, including mid-FLIGHT and mid-COOLDOWN.
REQ-022 After Reset deasserts, fire held high launches on the first edge, because fire_prev=0.

Verification
REQ-023 Launch and flight: Barrel=(100,200), p_direction=01, fire pulse -> next edge Shot=(100,200), active=1, shots_fired=1; 3 edges later ShotX=112, ShotY=200.
REQ-024 Left bound: BarrelX=6, p_direction=00 -> launch at X=6; next edge X=2; next edge active=0, state=10, X=2; after 30 more edges state=00.
REQ-025 Fire held high: only one launch; after COOLDOWN no relaunch while fire stays high; release then press -> shots_fired=2.
REQ-026 Mid-flight events:
- p_direction changed to 11 mid-flight: motion stays +X.
- hit=1 on the same edge as an out-of-bounds step: single termination, COOLDOWN of 30 edges.
REQ-027 Reset mid-flight: async Reset -> active=0, state=00, Shot=(0,0) before the next clock edge; fire edge after release launches normally.
REQ-028 Counter wrap: 256 launch/terminate cycles -> shots_fired returns to 0.

Source files
------------

// File: rtl/tank_shot_ctrl.sv
// Tank shot controller.
// Launches one shot from the barrel tip on a fire-key press and moves it
// SHOT_STEP pixels per frame along the facing latched at launch. The shot ends
// when it is hit or when its next step would leave the screen. A refire
// cooldown of COOLDOWN_FRAMES frames follows every shot.
module tank_shot_ctrl #(
    parameter int SHOT_STEP       = 4,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 639,
    parameter int Y_MIN           = 0,
    parameter int Y_MAX           = 479
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       fire,
    input  logic       hit,
    input  logic [9:0] BarrelX,
    input  logic [9:0] BarrelY,
    input  logic [1:0] p_direction,
    output logic [9:0] ShotX,
    output logic [9:0] ShotY,
    output logic       shot_active,
    output logic [1:0] ctrl_state,
    output logic [7:0] shots_fired
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_FLIGHT   = 2'b01,
        ST_COOLDOWN = 2'b10
    } state_t;

    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    // Counter is sized to hold COOLDOWN_FRAMES-1; a one-frame cooldown still needs one bit.
    localparam int             CD_W    = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
    localparam logic [CD_W-1:0] CD_INIT = CD_W'(COOLDOWN_FRAMES - 1);

    localparam logic [9:0]  STEP_10 = 10'(SHOT_STEP);
    // Bound limits in 11 bits so X_MIN+SHOT_STEP and X_MAX-SHOT_STEP cannot wrap.
    localparam logic [10:0] X_LO = 11'(X_MIN + SHOT_STEP);
    localparam logic [10:0] X_HI = 11'(X_MAX - SHOT_STEP);
    localparam logic [10:0] Y_LO = 11'(Y_MIN + SHOT_STEP);
    localparam logic [10:0] Y_HI = 11'(Y_MAX - SHOT_STEP);

    state_t          r_state;
    logic [9:0]      r_shot_x;
    logic [9:0]      r_shot_y;
    logic [1:0]      r_shot_dir;
    logic            r_shot_active;
    logic [7:0]      r_shots_fired;
    logic [CD_W-1:0] r_cd_cnt;
    logic            r_fire_prev;

    logic            w_fire_edge;
    logic            w_out_of_bounds;
    logic            w_terminate;
    logic [10:0]     w_x_ext;
    logic [10:0]     w_y_ext;

    assign w_fire_edge = fire & ~r_fire_prev;
    assign w_x_ext     = {1'b0, r_shot_x};
    assign w_y_ext     = {1'b0, r_shot_y};
    assign w_terminate = hit | w_out_of_bounds;

    // Would the next step along the latched direction cross a screen bound?
    always_comb begin
        w_out_of_bounds = 1'b0;
        case (r_shot_dir)
            DIR_LEFT:  w_out_of_bounds = (w_x_ext < X_LO);
            DIR_RIGHT: w_out_of_bounds = (w_x_ext > X_HI);
            DIR_DOWN:  w_out_of_bounds = (w_y_ext > Y_HI);
            DIR_UP:    w_out_of_bounds = (w_y_ext < Y_LO);
            default:   w_out_of_bounds = 1'b0;
        endcase
    end

    // Shot state machine with registered position, activity, counters and fire history.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= ST_IDLE;
            r_shot_x      <= '0;
            r_shot_y      <= '0;
            r_shot_dir    <= DIR_LEFT;
            r_shot_active <= 1'b0;
            r_shots_fired <= '0;
            r_cd_cnt      <= '0;
            r_fire_prev   <= 1'b0;
        end else begin
            // Fire history tracks the key in every state so a held key never relaunches.
            r_fire_prev <= fire;
            case (r_state)
                ST_IDLE: begin
                    if (w_fire_edge) begin
                        r_shot_x      <= BarrelX;
                        r_shot_y      <= BarrelY;
                        r_shot_dir    <= p_direction;
                        r_shot_active <= 1'b1;
                        r_shots_fired <= r_shots_fired + 8'd1;
                        r_state       <= ST_FLIGHT;
                    end
                end
                ST_FLIGHT: begin
                    if (w_terminate) begin
                        // Position freezes where the shot ended.
                        r_shot_active <= 1'b0;
                        r_cd_cnt      <= CD_INIT;
                        r_state       <= ST_COOLDOWN;
                    end else begin
                        case (r_shot_dir)
                            DIR_LEFT:  r_shot_x <= r_shot_x - STEP_10;
                            DIR_RIGHT: r_shot_x <= r_shot_x + STEP_10;
                            DIR_DOWN:  r_shot_y <= r_shot_y + STEP_10;
                            default:   r_shot_y <= r_shot_y - STEP_10;
                        endcase
                    end
                end
                ST_COOLDOWN: begin
                    if (r_cd_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cd_cnt <= r_cd_cnt - 1'b1;
                    end
                end
                default: begin
                    // Unused encoding recovers to a quiet IDLE.
                    r_state       <= ST_IDLE;
                    r_shot_active <= 1'b0;
                end
            endcase
        end
    end

    assign ShotX       = r_shot_x;
    assign ShotY       = r_shot_y;
    assign shot_active = r_shot_active;
    assign ctrl_state  = r_state;
    assign shots_fired = r_shots_fired;

endmodule

// File: tb/tb_tank_shot_ctrl.sv
// Directed bench for tank_shot_ctrl: a vector table for launch and flight,
// then hand-written sequences for bounds, cooldown, held fire, reset and wrap.
module tb_tank_shot_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       fire;
    logic       hit;
    logic [9:0] BarrelX;
    logic [9:0] BarrelY;
    logic [1:0] p_direction;
    logic [9:0] ShotX;
    logic [9:0] ShotY;
    logic       shot_active;
    logic [1:0] ctrl_state;
    logic [7:0] shots_fired;

    int n_cmp = 0;
    int n_err = 0;

    tank_shot_ctrl dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .fire        (fire),
        .hit         (hit),
        .BarrelX     (BarrelX),
        .BarrelY     (BarrelY),
        .p_direction (p_direction),
        .ShotX       (ShotX),
        .ShotY       (ShotY),
        .shot_active (shot_active),
        .ctrl_state  (ctrl_state),
        .shots_fired (shots_fired)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic       fire;
        logic       hit;
        logic [9:0] bx;
        logic [9:0] by;
        logic [1:0] dir;
        logic [9:0] ex;
        logic [9:0] ey;
        logic       eact;
        logic [1:0] est;
        logic [7:0] eshots;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One frame edge; outputs are then sampled on the falling edge.
    task automatic tick();
        @(posedge frame_clk);
        @(negedge frame_clk);
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
    endtask

    // Terminate edge just happened: 29 edges stay in COOLDOWN, the 30th reaches IDLE.
    task automatic run_cooldown(input string tag);
        repeat (29) tick();
        chk({tag, "_cd_29"}, int'(ctrl_state), 2);
        tick();
        chk({tag, "_cd_30"}, int'(ctrl_state), 0);
        $display("%s: cooldown ended, state=%0d", tag, ctrl_state);
    endtask

    initial begin
        Reset = 1'b1;
        fire = 1'b0;
        hit = 1'b0;
        BarrelX = 10'd0;
        BarrelY = 10'd0;
        p_direction = 2'b00;

        // fire hit  bx   by   dir   | x    y    act st shots
        vt[0] = '{1'b0, 1'b0, 10'd100, 10'd200, 2'b01, 10'd0,   10'd0,   1'b0, 2'd0, 8'd0};
        vt[1] = '{1'b1, 1'b0, 10'd100, 10'd200, 2'b01, 10'd100, 10'd200, 1'b1, 2'd1, 8'd1};
        vt[2] = '{1'b0, 1'b0, 10'd100, 10'd200, 2'b01, 10'd104, 10'd200, 1'b1, 2'd1, 8'd1};
        vt[3] = '{1'b0, 1'b0, 10'd300, 10'd50,  2'b11, 10'd108, 10'd200, 1'b1, 2'd1, 8'd1};
        vt[4] = '{1'b1, 1'b0, 10'd300, 10'd50,  2'b11, 10'd112, 10'd200, 1'b1, 2'd1, 8'd1};
        vt[5] = '{1'b0, 1'b1, 10'd300, 10'd50,  2'b11, 10'd112, 10'd200, 1'b0, 2'd2, 8'd1};
        vt[6] = '{1'b1, 1'b1, 10'd300, 10'd50,  2'b11, 10'd112, 10'd200, 1'b0, 2'd2, 8'd1};

        repeat (2) @(negedge frame_clk);
        chk("rst_x", int'(ShotX), 0);
        chk("rst_y", int'(ShotY), 0);
        chk("rst_act", int'(shot_active), 0);
        chk("rst_state", int'(ctrl_state), 0);
        chk("rst_shots", int'(shots_fired), 0);
        $display("reset: x=%0d y=%0d act=%0d st=%0d shots=%0d", ShotX, ShotY, shot_active, ctrl_state, shots_fired);
        Reset = 1'b0;

        // Launch right, change facing mid-flight, discarded fire, hit, cooldown.
        for (int i = 0; i < 7; i++) begin
            fire = vt[i].fire;
            hit = vt[i].hit;
            BarrelX = vt[i].bx;
            BarrelY = vt[i].by;
            p_direction = vt[i].dir;
            tick();
            chk($sformatf("v%0d_x", i), int'(ShotX), int'(vt[i].ex));
            chk($sformatf("v%0d_y", i), int'(ShotY), int'(vt[i].ey));
            chk($sformatf("v%0d_act", i), int'(shot_active), int'(vt[i].eact));
            chk($sformatf("v%0d_st", i), int'(ctrl_state), int'(vt[i].est));
            chk($sformatf("v%0d_shots", i), int'(shots_fired), int'(vt[i].eshots));
            $display("vec %0d: x=%0d y=%0d act=%0d st=%0d shots=%0d", i, ShotX, ShotY, shot_active, ctrl_state, shots_fired);
        end
        // Vector 6 was the first cooldown edge; 29 remain.
        fire = 1'b0;
        hit = 1'b0;
        repeat (28) tick();
        chk("tbl_cd_29", int'(ctrl_state), 2);
        tick();
        chk("tbl_cd_30", int'(ctrl_state), 0);
        $display("table: cooldown ended, state=%0d", ctrl_state);

        // Left bound: launch at X=6, step to 2, then terminate holding X=2.
        pulse_reset();
        BarrelX = 10'd6; BarrelY = 10'd50; p_direction = 2'b00; fire = 1'b1;
        tick();
        chk("left_launch_x", int'(ShotX), 6);
        chk("left_launch_act", int'(shot_active), 1);
        fire = 1'b0;
        tick();
        chk("left_step_x", int'(ShotX), 2);
        tick();
        chk("left_term_act", int'(shot_active), 0);
        chk("left_term_st", int'(ctrl_state), 2);
        chk("left_term_x", int'(ShotX), 2);
        chk("left_term_y", int'(ShotY), 50);
        $display("left: terminated at x=%0d", ShotX);
        run_cooldown("left");

        // Fire held high from launch through cooldown: only one launch.
        pulse_reset();
        BarrelX = 10'd630; BarrelY = 10'd20; p_direction = 2'b01; fire = 1'b1;
        tick();
        chk("held_launch_x", int'(ShotX), 630);
        tick();
        chk("held_step1_x", int'(ShotX), 634);
        tick();
        chk("held_step2_x", int'(ShotX), 638);
        tick();
        chk("held_term_x", int'(ShotX), 638);
        chk("held_term_st", int'(ctrl_state), 2);
        run_cooldown("held");
        repeat (3) tick();
        chk("held_no_relaunch_st", int'(ctrl_state), 0);
        chk("held_no_relaunch_shots", int'(shots_fired), 1);
        fire = 1'b0;
        tick();
        fire = 1'b1;
        tick();
        chk("held_repress_act", int'(shot_active), 1);
        chk("held_repress_shots", int'(shots_fired), 2);
        $display("held: shots=%0d after release and press", shots_fired);

        // Hit and bottom-bound overflow on the same edge: one termination.
        pulse_reset();
        BarrelX = 10'd10; BarrelY = 10'd476; p_direction = 2'b10; fire = 1'b1;
        tick();
        chk("both_launch_y", int'(ShotY), 476);
        fire = 1'b0; hit = 1'b1;
        tick();
        chk("both_term_st", int'(ctrl_state), 2);
        chk("both_term_y", int'(ShotY), 476);
        chk("both_term_x", int'(ShotX), 10);
        run_cooldown("both");
        chk("both_shots", int'(shots_fired), 1);
        hit = 1'b0;

        // Asynchronous reset mid-flight, then fire held through reset launches at once.
        pulse_reset();
        BarrelX = 10'd200; BarrelY = 10'd100; p_direction = 2'b01; fire = 1'b1;
        tick();
        fire = 1'b0;
        tick();
        chk("arst_pre_x", int'(ShotX), 204);
        fire = 1'b1;
        #1 Reset = 1'b1;
        #1;
        chk("arst_act", int'(shot_active), 0);
        chk("arst_st", int'(ctrl_state), 0);
        chk("arst_x", int'(ShotX), 0);
        chk("arst_y", int'(ShotY), 0);
        chk("arst_shots", int'(shots_fired), 0);
        #1 Reset = 1'b0;
        tick();
        chk("arst_relaunch_act", int'(shot_active), 1);
        chk("arst_relaunch_x", int'(ShotX), 200);
        chk("arst_relaunch_shots", int'(shots_fired), 1);
        $display("arst: relaunch x=%0d shots=%0d", ShotX, shots_fired);

        // 256 launches at the top bound: counter wraps back to zero.
        pulse_reset();
        BarrelX = 10'd40; BarrelY = 10'd2; p_direction = 2'b11; fire = 1'b0;
        for (int n = 1; n <= 256; n++) begin
            fire = 1'b1;
            tick();
            fire = 1'b0;
            tick();
            if (n == 1) begin
                chk("wrap_up_term_y", int'(ShotY), 2);
                chk("wrap_up_term_st", int'(ctrl_state), 2);
            end
            repeat (30) tick();
            if (n == 255) chk("wrap_255", int'(shots_fired), 255);
        end
        chk("wrap_256", int'(shots_fired), 0);
        chk("wrap_idle", int'(ctrl_state), 0);
        $display("wrap: shots=%0d after 256 launches", shots_fired);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
